uart_fifo_tx: RTL and testbench
===============================

# uart_fifo_tx

UART transmitter that drains the shared 16×8 UART FIFO from its read side. It pops one byte at a time whenever the FIFO is non-empty and transmission is enabled. Each byte is serialized as an 8N1 frame on `tx`. It is the consumer end of the FIFO: the RX path pushes into the FIFO, and this block pops from it.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- Derived constant `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer division). Legal only if ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_en`  in  1  permits starting a new frame; it has no effect on a frame in progress.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_data`  in  8  FIFO head byte. It is first-word-fall-through: valid while `fifo_empty`=0, in the same cycle as `pop`.
- `fifo_pop`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- Registers: 8-bit shift register, clock-per-bit counter of width `$clog2(CLKS_PER_BIT)`, 3-bit bit index.
- IDLE:
  - `tx`=1.
  - `fifo_pop` = (state==IDLE) && `tx_en` && !`fifo_empty`. It is decoded combinationally from the registered state and the inputs.
  - On a pop cycle, latch `fifo_r_data` into the shift register, clear the counter, and go to START.
- START:
  - `tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA with bit index 0.
- DATA:
  - `tx` = shift register bit[index], LSB first.
  - Each bit lasts `CLKS_PER_BIT` clocks.
  - After index 7 completes, go to STOP.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` clocks.
  - `tx_done`=1 on the final clock, then go to IDLE.
- `tx_busy` = (state != IDLE).
- `tx` is driven from a register, glitch-free; `tx_busy` and `tx_done` are also registered.
- `fifo_pop` is never asserted while `fifo_empty`=1 or outside IDLE. Exactly one pop is issued per frame.
- `fifo_empty` and `fifo_r_data` are ignored outside IDLE.
- `tx_en` falling mid-frame: the frame completes normally, then the block stays in IDLE.

## Timing
- Let the pop occur in cycle T0 and N = `CLKS_PER_BIT`.
- Start bit: `tx`=0 in cycles T0+1 … T0+N.
- Data bit k: cycles T0+(k+1)N+1 … T0+(k+2)N.
- Stop bit: cycles T0+9N+1 … T0+10N.
- `tx_done`=1 only in T0+10N.
- `tx_busy`=1 in T0+1 … T0+10N.
- IDLE resumes at T0+10N+1. The earliest next pop is at T0+10N+1, so streaming frames are spaced 10N+1 clocks apart with one extra idle-high clock between frames.
- Reset values (applied immediately when `rst` rises, held while high):
  - state IDLE;
  - `tx`=1, `fifo_pop`=0, `tx_busy`=0, `tx_done`=0;
  - counters 0.
- Reset mid-frame: the current byte is dropped and not re-popped. The first pop after release happens no earlier than the first clock edge with `rst`=0.

## Test plan
Use `CLK_FREQ`=1_600_000 and `BAUD_RATE`=100_000, so N=16. The bench FIFO model is FWFT.

- **Reset and idle:**
  - Stimulus: `rst`=1 for 5 cycles, then `fifo_empty`=1 and `tx_en`=1 for 200 cycles.
  - Required: `tx`=1, `fifo_pop`=0, `tx_busy`=0 and `tx_done`=0 throughout.
- **Single byte:**
  - Stimulus: push 0xA5.
  - Required: exactly one `fifo_pop` pulse.
  - `tx`, sampled mid-bit every 16 clocks, is 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_done` pulses once, 160 clocks after the pop.
- **Streaming:**
  - Stimulus: preload 0x00, 0xFF, 0x55.
  - Required: exactly 3 pops, spaced 161 clocks apart.
  - A bench UART decoder recovers 0x00, 0xFF, 0x55 in order; the FIFO model ends empty and no 4th pop occurs.
- **Enable gating:**
  - Stimulus 1: `tx_en`=0 with 2 bytes queued for 300 cycles.
  - Required: no pop and `tx`=1. After `tx_en`=1, the first byte starts.
  - Stimulus 2: drop `tx_en` during data bit 2.
  - Required: the frame completes intact, then no further pop while `tx_en`=0.
- **Reset mid-frame:**
  - Stimulus: send 0x3C and assert `rst` during data bit 3.
  - Required: `tx`=1 and `tx_busy`=0 without waiting for a clock edge.
  - After release, the next queued byte 0x81 is transmitted as a complete fresh frame, and 0x3C is not resent.
- **Late arrival:**
  - Stimulus: start a frame with 0x01 and push 0x02 while in DATA.
  - Required: the pop for 0x02 occurs exactly 161 clocks after the first pop, with no pop mid-frame.

Source files
------------

// File: rtl/uart_fifo_tx_if.sv
// Read-side handshake between the shared UART FIFO and its transmit consumer.
// master = consumer (pops), slave = FIFO (FWFT head byte plus empty flag).
interface uart_fifo_tx_if;
   localparam int unsigned DATA_W = 8;

   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_r_data;
   logic              fifo_pop;

   modport master (
      output fifo_pop,
      input  fifo_empty,
      input  fifo_r_data
   );

   modport slave (
      input  fifo_pop,
      output fifo_empty,
      output fifo_r_data
   );
endinterface

// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that drains a first-word-fall-through FIFO one byte per frame.
// tx, tx_busy and tx_done are registered from the next-state values so they line up with the state.
module uart_fifo_tx #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tx_en,
   uart_fifo_tx_if.master fifo,
   output logic           tx,
   output logic           tx_busy,
   output logic           tx_done
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned IDX_W        = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             state, state_d;
   logic [DATA_W-1:0]  sr, sr_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [IDX_W-1:0]   idx, idx_d;
   logic               tx_d, busy_d, done_d;
   logic               pop_c;
   logic               bit_end_c;

   assign bit_end_c     = (cnt == CNT_LAST);
   assign fifo.fifo_pop = pop_c;

   // Next-state, datapath and look-ahead output decode
   always_comb begin
      state_d = state;
      sr_d    = sr;
      cnt_d   = cnt;
      idx_d   = idx;
      pop_c   = 1'b0;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      case (state)
         IDLE: begin
            // Gated by rst so the FIFO never loses a byte while the block is held in reset
            if (!rst && tx_en && !fifo.fifo_empty) begin
               pop_c   = 1'b1;
               sr_d    = fifo.fifo_r_data;
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               cnt_d = '0;
               idx_d = idx + IDX_W'(1);
               if (idx == IDX_W'(DATA_W - 1)) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end_c) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sr_d[idx_d];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         idx     <= '0;
         tx      <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         state   <= state_d;
         sr      <= sr_d;
         cnt     <= cnt_d;
         idx     <= idx_d;
         tx      <= tx_d;
         tx_busy <= busy_d;
         tx_done <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx with N=16 clocks per bit and an FWFT FIFO model.
// Every cycle's outputs are logged; tests check pop/done timing and decode the tx line.
module tb_uart_fifo_tx;

   logic       clk;
   logic       rst;
   logic       tx_en;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;
   logic       fifo_empty;
   logic [7:0] fifo_r_data;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic       s_pop;

   logic [7:0] q[$];
   logic [7:0] popped[$];
   logic tx_h[$];
   logic pop_h[$];
   logic busy_h[$];
   logic done_h[$];

   uart_fifo_tx_if fifo_bus ();
   assign fifo_bus.fifo_empty  = fifo_empty;
   assign fifo_bus.fifo_r_data = fifo_r_data;

   uart_fifo_tx #(
      .CLK_FREQ (1_600_000),
      .BAUD_RATE(100_000)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .tx_en  (tx_en),
      .fifo   (fifo_bus),
      .tx     (tx),
      .tx_busy(tx_busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   function automatic void sync_fifo();
      fifo_empty  = (q.size() == 0);
      fifo_r_data = (q.size() != 0) ? q[0] : 8'h00;
   endfunction

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      sync_fifo();
   endtask

   // One clock: log outputs at the falling edge, then retire a pop after the rising edge
   task automatic cycle();
      logic [7:0] dummy;
      @(negedge clk);
      s_pop = fifo_bus.fifo_pop;
      tx_h.push_back(tx);
      pop_h.push_back(fifo_bus.fifo_pop);
      busy_h.push_back(tx_busy);
      done_h.push_back(tx_done);
      if (s_pop === 1'b1) popped.push_back(fifo_r_data);
      cyc++;
      @(posedge clk);
      #1;
      if (s_pop === 1'b1 && q.size() != 0) begin
         dummy = q.pop_front();
      end
      sync_fifo();
   endtask

   task automatic run_until(input int target);
      while (cyc < target) cycle();
   endtask

   function automatic logic hist(input int which, input int i);
      if (i < 0 || i >= tx_h.size()) return 1'bx;
      case (which)
         0:       return tx_h[i];
         1:       return pop_h[i];
         2:       return busy_h[i];
         default: return done_h[i];
      endcase
   endfunction

   function automatic int count_val(input int which, input int a, input int b, input logic val);
      int n = 0;
      for (int i = a; i < b; i++) if (hist(which, i) === val) n++;
      return n;
   endfunction

   function automatic int nth_hi(input int which, input int a, input int b, input int k);
      int n = 0;
      for (int i = a; i < b; i++) begin
         if (hist(which, i) === 1'b1) begin
            n++;
            if (n == k) return i;
         end
      end
      return -1;
   endfunction

   function automatic int count_not_idle(input int a, input int b);
      int n = 0;
      for (int i = a; i < b; i++)
         if (hist(0, i) !== 1'b1 || hist(1, i) !== 1'b0 || hist(2, i) !== 1'b0 || hist(3, i) !== 1'b0) n++;
      return n;
   endfunction

   // Line decoder: finds start-bit falling edges and samples mid-bit; bad framing adds 16 to n
   task automatic decode(input int a, input int b, output int n, output logic [31:0] v);
      int i;
      logic [7:0] d;
      n = 0;
      v = '0;
      i = a + 1;
      while (i + 152 < b) begin
         if (hist(0, i) === 1'b0 && hist(0, i - 1) === 1'b1) begin
            for (int k = 0; k < 8; k++) d[k] = hist(0, i + 7 + 16 * (k + 1));
            if (hist(0, i + 7) === 1'b0 && hist(0, i + 7 + 16 * 9) === 1'b1) n++;
            else n += 16;
            v = (v << 8) | 32'(d);
            i = i + 150;
         end else begin
            i++;
         end
      end
   endtask

   task automatic wait_pop(input int budget, output int t0);
      int left = budget;
      t0 = -1;
      while (left > 0 && t0 < 0) begin
         cycle();
         if (s_pop === 1'b1) t0 = cyc - 1;
         left--;
      end
      checks++;
      if (t0 < 0) begin
         errors++;
         $display("FAIL wait_pop: no pop within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      int bad;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_bus.fifo_pop !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: tx=%b busy=%b done=%b pop=%b expected 1 0 0 0",
                  tx, tx_busy, tx_done, fifo_bus.fifo_pop);
      end
      checks++;
      tx_en = 1'b1;
      repeat (5) cycle();
      bad = count_not_idle(0, 5);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL reset_outputs: %0d non-idle cycles, expected 0", bad);
      end
      rst = 1'b0;
      repeat (200) cycle();
      bad = count_not_idle(5, 205);
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL idle_empty: %0d non-idle cycles, expected 0", bad);
      end
   endtask

   task automatic test_single_byte();
      int t0, n;
      logic [9:0] got;
      push(8'hA5);
      wait_pop(5, t0);
      run_until(t0 + 200);
      n = count_val(1, t0, t0 + 200, 1'b1);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL single_pops: got %0d expected 1", n);
      end
      for (int k = 0; k < 10; k++) got[k] = hist(0, t0 + 8 + 16 * k);
      checks++;
      if (got !== {1'b1, 8'hA5, 1'b0}) begin
         errors++;
         $display("FAIL single_bits: got %b expected %b", got, {1'b1, 8'hA5, 1'b0});
      end
      checks++;
      if (hist(0, t0) !== 1'b1 || count_val(0, t0 + 1, t0 + 17, 1'b0) !== 16 || hist(0, t0 + 17) !== 1'b1
          || count_val(0, t0 + 145, t0 + 162, 1'b1) !== 17) begin
         errors++;
         $display("FAIL single_edges: start-low=%0d stop-high=%0d expected 16 17",
                  count_val(0, t0 + 1, t0 + 17, 1'b0), count_val(0, t0 + 145, t0 + 162, 1'b1));
      end
      n = count_val(3, t0, t0 + 200, 1'b1);
      checks++;
      if (n !== 1 || nth_hi(3, t0, t0 + 200, 1) !== t0 + 160) begin
         errors++;
         $display("FAIL single_done: count=%0d at=%0d expected 1 at %0d",
                  n, nth_hi(3, t0, t0 + 200, 1), t0 + 160);
      end
      n = count_val(2, t0, t0 + 200, 1'b1);
      checks++;
      if (n !== 160 || nth_hi(2, t0, t0 + 200, 1) !== t0 + 1) begin
         errors++;
         $display("FAIL single_busy: count=%0d first=%0d expected 160 first %0d",
                  n, nth_hi(2, t0, t0 + 200, 1), t0 + 1);
      end
   endtask

   task automatic test_streaming();
      int s, n, p1, p2, p3;
      logic [31:0] v;
      push(8'h00);
      push(8'hFF);
      push(8'h55);
      s = cyc;
      run_until(s + 600);
      n  = count_val(1, s, s + 600, 1'b1);
      p1 = nth_hi(1, s, s + 600, 1);
      p2 = nth_hi(1, s, s + 600, 2);
      p3 = nth_hi(1, s, s + 600, 3);
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL stream_pops: got %0d expected 3", n);
      end
      checks++;
      if (p2 - p1 !== 161 || p3 - p2 !== 161) begin
         errors++;
         $display("FAIL stream_spacing: got %0d,%0d expected 161,161", p2 - p1, p3 - p2);
      end
      decode(s, s + 600, n, v);
      checks++;
      if (n !== 3 || v !== 32'h0000_FF55) begin
         errors++;
         $display("FAIL stream_decode: got n=%0d data=%h expected n=3 data=0000ff55", n, v);
      end
      checks++;
      if (q.size() !== 0) begin
         errors++;
         $display("FAIL stream_fifo_empty: %0d entries left, expected 0", q.size());
      end
   endtask

   task automatic test_enable_gating();
      int s, t0, n;
      logic [31:0] v;
      tx_en = 1'b0;
      push(8'h11);
      push(8'h22);
      s = cyc;
      run_until(s + 300);
      n = count_val(1, s, s + 300, 1'b1) + count_val(0, s, s + 300, 1'b0);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL enable_off: %0d pop/low-tx cycles, expected 0", n);
      end
      tx_en = 1'b1;
      wait_pop(3, t0);
      checks++;
      if (t0 !== s + 300) begin
         errors++;
         $display("FAIL enable_on: pop at %0d expected %0d", t0, s + 300);
      end
      // Drop enable in the middle of data bit 2
      run_until(t0 + 55);
      tx_en = 1'b0;
      run_until(t0 + 400);
      n = count_val(1, t0, t0 + 400, 1'b1);
      checks++;
      if (n !== 1) begin
         errors++;
         $display("FAIL enable_drop_pops: got %0d expected 1", n);
      end
      decode(t0, t0 + 400, n, v);
      checks++;
      if (n !== 1 || v !== 32'h0000_0011 || nth_hi(3, t0, t0 + 400, 1) !== t0 + 160) begin
         errors++;
         $display("FAIL enable_drop_frame: n=%0d data=%h done=%0d expected 1 00000011 %0d",
                  n, v, nth_hi(3, t0, t0 + 400, 1), t0 + 160);
      end
      checks++;
      if (q.size() !== 1) begin
         errors++;
         $display("FAIL enable_drop_fifo: %0d entries expected 1", q.size());
      end
      q.delete();
      sync_fifo();
   endtask

   task automatic test_reset_mid_frame();
      int t0, r0, rel, n;
      logic [31:0] v;
      tx_en = 1'b1;
      push(8'h3C);
      push(8'h81);
      wait_pop(3, t0);
      run_until(t0 + 70);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_async: tx=%b busy=%b expected 1 0", tx, tx_busy);
      end
      r0 = cyc;
      repeat (4) cycle();
      n = count_not_idle(r0, r0 + 4);
      checks++;
      if (n !== 0) begin
         errors++;
         $display("FAIL reset_mid_hold: %0d non-idle cycles, expected 0", n);
      end
      rst = 1'b0;
      rel = cyc;
      run_until(rel + 250);
      n = count_val(1, rel, rel + 250, 1'b1);
      checks++;
      if (n !== 1 || nth_hi(1, rel, rel + 250, 1) !== rel || popped.size() == 0
          || popped[popped.size() - 1] !== 8'h81) begin
         errors++;
         $display("FAIL reset_mid_repop: pops=%0d first=%0d expected 1 at %0d of 0x81",
                  n, nth_hi(1, rel, rel + 250, 1), rel);
      end
      decode(rel, rel + 250, n, v);
      checks++;
      if (n !== 1 || v !== 32'h0000_0081) begin
         errors++;
         $display("FAIL reset_mid_decode: n=%0d data=%h expected n=1 data=00000081", n, v);
      end
   endtask

   task automatic test_late_arrival();
      int t0, n;
      logic [31:0] v;
      tx_en = 1'b1;
      repeat (3) cycle();
      push(8'h01);
      wait_pop(3, t0);
      run_until(t0 + 40);
      push(8'h02);
      run_until(t0 + 400);
      n = count_val(1, t0, t0 + 400, 1'b1);
      checks++;
      if (n !== 2 || nth_hi(1, t0, t0 + 400, 2) !== t0 + 161) begin
         errors++;
         $display("FAIL late_pop: pops=%0d second=%0d expected 2 second at %0d",
                  n, nth_hi(1, t0, t0 + 400, 2), t0 + 161);
      end
      decode(t0, t0 + 400, n, v);
      checks++;
      if (n !== 2 || v !== 32'h0000_0102) begin
         errors++;
         $display("FAIL late_decode: n=%0d data=%h expected n=2 data=00000102", n, v);
      end
   endtask

   initial begin
      clk   = 1'b0;
      rst   = 1'b0;
      tx_en = 1'b0;
      sync_fifo();
      #2 rst = 1'b1;
      #1;
      test_reset();
      test_single_byte();
      test_streaming();
      test_enable_gating();
      test_reset_mid_frame();
      test_late_arrival();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
